mem_port_scheduler: RTL and testbench

Round-robin burst scheduler sharing one memory/interconnect port among N_REQ requesters. It sits in front of the shared port, after the access servicer trees. Unlike the single-cycle conflict flop, it holds a grant for a multi-beat burst, paces beats on port back-pressure and returns per-requester completion or abort pulses. Fairness rule: the last winner has the lowest priority in the next arbitration.

---
 rtl/mem_port_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_scheduler
// Description : Round-robin burst scheduler for one shared memory port.
//               It grants one requester for a whole multi-beat burst, paces
//               beats on mem_ready, and pulses done/abort per requester.
//               The last winner has the lowest priority in the next
//               arbitration round.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_scheduler #(
  parameter int N_REQ      = 8,
  parameter int DATA_WIDTH = 132,
  parameter int LEN_W      = 4,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*LEN_W-1:0]        req_len,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic [N_REQ-1:0]              abort,
  output logic                          mem_valid,
  output logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          mem_last,
  input  logic                          mem_ready,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_nxt;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  beat_cnt_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_q_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [N_REQ-1:0]  done_nxt;
  logic [N_REQ-1:0]  abort_nxt;
  logic [ID_W-1:0]   grant_id_nxt;

  // Per-requester views of the flattened length and payload buses.
  logic [LEN_W-1:0]      len_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // --------------------------------------------------------------------------
  // Round-robin pick: rotate the request vector so rr_ptr lands on bit 0,
  // take the first set bit, then add rr_ptr back modulo N_REQ.
  // --------------------------------------------------------------------------
  logic [2*N_REQ-1:0] req_rot;
  logic [ID_W-1:0]    offset;
  logic               found;
  logic [ID_W:0]      win_sum;
  logic [ID_W-1:0]    winner;

  // Find the first requester at or after rr_ptr, wrapping around.
  always_comb begin
    req_rot = {req, req} >> rr_ptr;
    found   = 1'b0;
    offset  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found  = 1'b1;
        offset = ID_W'(i);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (win_sum >= (ID_W+1)'(N_REQ)) begin
      winner = ID_W'(win_sum - (ID_W+1)'(N_REQ));
    end else begin
      winner = win_sum[ID_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Port-side signals. A grantee that drops its request mid-burst has its
  // beat suppressed in the same cycle so no stale payload reaches the port.
  // --------------------------------------------------------------------------
  logic            cur_req;
  logic            accept;
  logic            last_beat;
  logic [ID_W-1:0] ptr_after;

  assign cur_req   = req[grant_id];
  assign busy      = (state == XFER);
  assign mem_valid = busy && cur_req;
  assign last_beat = (beat_cnt == len_q);
  assign mem_last  = busy && last_beat;
  assign mem_data  = data_arr[grant_id];
  assign accept    = mem_valid && mem_ready;
  // The finishing owner drops to lowest priority next round.
  assign ptr_after = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);

  // Next-state and next-register values; everything holds unless told otherwise.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    grant_id_nxt = grant_id;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    len_q_nxt    = len_q;
    done_nxt     = '0;
    abort_nxt    = '0;

    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          grant_id_nxt    = winner;
          len_q_nxt       = len_arr[winner];
          beat_cnt_nxt    = '0;
          state_nxt       = XFER;
        end
      end

      XFER: begin
        if (accept) begin
          if (last_beat) begin
            // Burst complete; beat_cnt stays put so it never wraps.
            done_nxt[grant_id] = 1'b1;
            gnt_nxt            = '0;
            rr_ptr_nxt         = ptr_after;
            state_nxt          = GAP;
          end else begin
            beat_cnt_nxt = beat_cnt + LEN_W'(1);
          end
        end else if (!cur_req) begin
          // Requester withdrew; accepted beats stand, no done is issued.
          abort_nxt[grant_id] = 1'b1;
          gnt_nxt             = '0;
          rr_ptr_nxt          = ptr_after;
          state_nxt           = GAP;
        end
      end

      GAP: begin
        // One all-zero grant cycle between owners.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant, pointer, burst bookkeeping and completion pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      done     <= '0;
      abort    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
    end else begin
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      abort    <= abort_nxt;
      grant_id <= grant_id_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      len_q    <= len_q_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_scheduler
// Description : Self-checking bench for mem_port_scheduler. A transaction
//               level model (owner / beats sent / pointer) predicts outputs
//               every cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_scheduler;

  localparam int N  = 8;
  localparam int DW = 132;
  localparam int LW = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt, done, abort;
  logic            mem_valid, mem_last, mem_ready;
  logic [DW-1:0]   mem_data;
  logic [IW-1:0]   grant_id;
  logic            busy;

  int tests = 0;
  int fails = 0;
  bit auto_rel = 1'b0;

  always #5 clk = ~clk;

  mem_port_scheduler #(.N_REQ(N), .DATA_WIDTH(DW), .LEN_W(LW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .req_data(req_data),
    .gnt(gnt), .done(done), .abort(abort), .mem_valid(mem_valid),
    .mem_data(mem_data), .mem_last(mem_last), .mem_ready(mem_ready),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(int i);
    return {4'(i), {4{32'hC0DE_0000 + 32'(i)}}};
  endfunction

  // ---------------- behavioural model ----------------
  int        m_owner;   // -1 when nobody holds the port
  int        m_beats;   // beats already accepted in the current burst
  int        m_len;     // burst length minus one
  int        m_ptr;     // first requester looked at next round
  int        m_gid;
  bit        m_gap;
  logic [N-1:0] m_done, m_abort;

  // ---------------- observation logs ----------------
  int        glog[$];
  int        gcyc[$];
  int        done_cnt[N];
  int        abort_cnt[N];
  int        done_acc[N];
  int        acc_cnt;
  int        cyc = 0;
  logic [N-1:0] prev_gnt = '0;

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_len = 0; m_ptr = 0; m_gid = 0; m_gap = 0;
    m_done = '0; m_abort = '0;
  endtask

  task automatic model_step();
    int  o;
    bit  sent;
    m_done  = '0;
    m_abort = '0;
    if (m_owner >= 0) begin
      o    = m_owner;
      sent = req[o] && mem_ready;
      if (sent && m_beats == m_len) begin
        m_done[o] = 1'b1; m_ptr = (o + 1) % N; m_owner = -1; m_gap = 1;
      end else if (sent) begin
        m_beats++;
      end else if (!req[o]) begin
        m_abort[o] = 1'b1; m_ptr = (o + 1) % N; m_owner = -1; m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_gid   = m_owner;
          m_beats = 0;
          m_len   = int'(req_len[m_owner*LW +: LW]);
        end
      end
    end
  endtask

  // Per-cycle comparison against the model, then event logging and model advance.
  always @(negedge clk) begin
    logic [N-1:0] e_gnt;
    bit           e_valid;
    cyc++;
    if (!rst_n) model_reset();
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_valid = (m_owner >= 0) && req[m_owner];
    check("gnt", gnt, e_gnt);
    check("busy", busy, m_owner >= 0);
    check("mem_valid", mem_valid, e_valid);
    check("mem_last", mem_last, (m_owner >= 0) && (m_beats == m_len));
    check("grant_id", grant_id, m_gid);
    check("done", done, m_done);
    check("abort", abort, m_abort);
    check("pulse_onehot", $countones(done | abort) <= 1, 1'b1);
    if (e_valid) check("mem_data", mem_data, req_data[m_owner*DW +: DW]);

    if (rst_n) begin
      if (gnt != 0 && prev_gnt == 0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) begin glog.push_back(i); gcyc.push_back(cyc); end
      end
      if (mem_valid && mem_ready) acc_cnt++;
      for (int i = 0; i < N; i++) begin
        if (done[i])  begin done_cnt[i]++; done_acc[i] = acc_cnt; end
        if (abort[i]) abort_cnt[i]++;
      end
    end
    prev_gnt = gnt;
    if (rst_n) model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (auto_rel) req = req & ~(done | abort);
    end
  endtask

  task automatic set_req(int i, int len);
    req[i] = 1'b1;
    req_len[i*LW +: LW] = LW'(len);
  endtask

  task automatic clear_logs();
    glog.delete(); gcyc.delete();
    acc_cnt = 0;
    for (int i = 0; i < N; i++) begin done_cnt[i] = 0; abort_cnt[i] = 0; done_acc[i] = 0; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0; req_len = '0; mem_ready = 1'b1; auto_rel = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_len = '0; mem_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pattern(i);
    model_reset();
    clear_logs();

    // Reset state
    tick(2);
    check("rst_gnt", gnt, 8'h00);
    check("rst_valid", mem_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_gid", grant_id, 3'd0);
    do_reset();

    // Single requester 3, three-beat burst
    set_req(3, 2); auto_rel = 1'b1;
    tick(1);
    check("t1_gnt", gnt, 8'h08);
    check("t1_valid", mem_valid, 1'b1);
    check("t1_data", mem_data, pattern(3));
    tick(2);
    check("t1_last", mem_last, 1'b1);
    tick(1);
    check("t1_done", done, 8'h08);
    check("t1_gap_gnt", gnt, 8'h00);
    tick(1);
    check("t1_done_once", done, 8'h00);
    set_req(3, 0); set_req(4, 0);
    tick(1);
    check("t1_next_is_4", grant_id, 3'd4);
    tick(6);
    check("t1_order_len", glog.size(), 3);
    if (glog.size() == 3) begin
      check("t1_order0", glog[0], 3);
      check("t1_order1", glog[1], 4);
      check("t1_order2", glog[2], 3);
    end
    check("t1_accepts", acc_cnt, 5);
    check("t1_done3", done_cnt[3], 2);

    // All eight requesting, single-beat bursts
    do_reset();
    req = 8'hFF;
    tick(27);
    check("t2_grants", glog.size(), 9);
    for (int k = 0; k < 9 && k < glog.size(); k++) check("t2_order", glog[k], k % N);
    for (int k = 1; k < 9 && k < gcyc.size(); k++) check("t2_period", gcyc[k] - gcyc[k-1], 3);

    // Back-pressure on requester 5, four-beat burst
    do_reset();
    set_req(5, 3); auto_rel = 1'b1;
    tick(2);
    mem_ready = 1'b0;
    tick(4);
    check("t3_stall_valid", mem_valid, 1'b1);
    check("t3_stall_data", mem_data, pattern(5));
    check("t3_stall_acc", acc_cnt, 1);
    check("t3_no_early_done", done_cnt[5], 0);
    mem_ready = 1'b1;
    tick(4);
    check("t3_accepts", acc_cnt, 4);
    check("t3_done5", done_cnt[5], 1);
    check("t3_done_after4", done_acc[5], 4);

    // Requester 2 withdraws after one of four beats
    do_reset();
    set_req(2, 3); set_req(3, 0); auto_rel = 1'b1;
    tick(2);
    req[2] = 1'b0;
    #1;
    check("t4_valid_gated", mem_valid, 1'b0);
    tick(1);
    check("t4_abort", abort, 8'h04);
    check("t4_no_done", done, 8'h00);
    tick(2);
    check("t4_next_gid", grant_id, 3'd3);
    check("t4_next_gnt", gnt, 8'h08);
    tick(3);
    check("t4_abort_cnt", abort_cnt[2], 1);
    check("t4_done2", done_cnt[2], 0);
    check("t4_done3", done_cnt[3], 1);

    // Last beat accepted while requester 6 drops at the same edge
    do_reset();
    set_req(6, 1);
    tick(3);
    req[6] = 1'b0;
    check("t5_done", done, 8'h40);
    check("t5_abort", abort, 8'h00);
    tick(2);
    check("t5_abort_cnt", abort_cnt[6], 0);
    check("t5_done_cnt", done_cnt[6], 1);

    // Reset mid-burst
    do_reset();
    set_req(1, 0); auto_rel = 1'b1;
    tick(4);
    set_req(0, 3);
    tick(2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_gnt", gnt, 8'h00);
    check("t6_async_valid", mem_valid, 1'b0);
    check("t6_async_busy", busy, 1'b0);
    set_req(2, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("t6_regrant_gid", grant_id, 3'd0);
    check("t6_regrant_gnt", gnt, 8'h01);
    tick(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
